// File: rtl/or1200_if_bus_resp.sv
// Instruction-side responder: one Wishbone classic read per fetch request, registered response to the fetch stage.
// Optional one-entry refetch buffer enabled by OR1200_IF_BUS_RESP_REFETCH_BUF_EN.
module or1200_if_bus_resp #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [3:0]  TAG_NI  = 4'h0,
    parameter logic [3:0]  TAG_BE  = 4'hb
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icpu_cycstb_i,
    input  logic [31:0] icpu_adr_i,
    input  logic        icpu_flush_i,
    output logic [31:0] icpu_dat_o,
    output logic        icpu_ack_o,
    output logic        icpu_err_o,
    output logic [31:0] icpu_adr_o,
    output logic [3:0]  icpu_tag_o,
    input  logic        ic_inv_i,
    output logic        iwb_cyc_o,
    output logic        iwb_stb_o,
    output logic [31:0] iwb_adr_o,
    output logic [3:0]  iwb_sel_o,
    output logic        iwb_we_o,
    input  logic [31:0] iwb_dat_i,
    input  logic        iwb_ack_i,
    input  logic        iwb_err_i,
    input  logic        iwb_rty_i
);

    localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // S_GAP is the single idle bus cycle between a retry and the reissue.
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_GAP, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic [31:0] wb_adr_q, wb_adr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] cpu_adr_q, cpu_adr_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [3:0]  tag_q, tag_d;

    logic        abort;
    logic        timeout_hit;
    logic        bus_end;
    logic        wb_fill;
    logic        buf_hit;
    logic [31:0] buf_rd_dat;

    assign abort       = icpu_flush_i | ~icpu_cycstb_i;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign bus_end     = iwb_ack_i | iwb_err_i | iwb_rty_i | timeout_hit;

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        wb_adr_d  = wb_adr_q;
        cnt_d     = cnt_q;
        dat_d     = dat_q;
        cpu_adr_d = cpu_adr_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        wb_fill   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (icpu_cycstb_i && !icpu_flush_i) begin
                    cpu_adr_d = {icpu_adr_i[31:2], 2'b00};
                    if (icpu_adr_i[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else if (buf_hit) begin
                        ack_d = 1'b1;
                        dat_d = buf_rd_dat;
                    end else begin
                        cyc_d    = 1'b1;
                        wb_adr_d = {icpu_adr_i[31:2], 2'b00};
                        cnt_d    = '0;
                        state_d  = S_BUS;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 1'b1;
                if (abort) begin
                    // A bus cycle that terminates in the abort cycle needs no drain.
                    if (bus_end) begin
                        cyc_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (iwb_ack_i) begin
                    dat_d   = iwb_dat_i;
                    ack_d   = 1'b1;
                    wb_fill = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (iwb_err_i) begin
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (iwb_rty_i) begin
                    cyc_d   = 1'b0;
                    state_d = S_GAP;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    cyc_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cyc_d   = 1'b1;
                    state_d = S_BUS;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (bus_end) begin
                    cyc_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        tag_d = err_d ? TAG_BE : TAG_NI;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= 1'b0;
            wb_adr_q  <= '0;
            cnt_q     <= '0;
            dat_q     <= '0;
            cpu_adr_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            tag_q     <= TAG_NI;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            wb_adr_q  <= wb_adr_d;
            cnt_q     <= cnt_d;
            dat_q     <= dat_d;
            cpu_adr_q <= cpu_adr_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            tag_q     <= tag_d;
        end
    end

`ifdef OR1200_IF_BUS_RESP_REFETCH_BUF_EN
    logic        buf_vld_q, buf_vld_d;
    logic [29:0] buf_adr_q, buf_adr_d;
    logic [31:0] buf_dat_q, buf_dat_d;

    assign buf_hit    = buf_vld_q && (buf_adr_q == icpu_adr_i[31:2]) && !ic_inv_i;
    assign buf_rd_dat = buf_dat_q;

    // Invalidation wins over a fill arriving in the same cycle.
    always_comb begin
        buf_vld_d = buf_vld_q;
        buf_adr_d = buf_adr_q;
        buf_dat_d = buf_dat_q;
        if (wb_fill) begin
            buf_vld_d = 1'b1;
            buf_adr_d = wb_adr_q[31:2];
            buf_dat_d = iwb_dat_i;
        end
        if (ic_inv_i || err_d) begin
            buf_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q <= 1'b0;
        end else begin
            buf_vld_q <= buf_vld_d;
        end
    end

    // NOTE: buffer payload has no reset; it is never read while the valid bit is clear.
    always_ff @(posedge clk) begin
        buf_adr_q <= buf_adr_d;
        buf_dat_q <= buf_dat_d;
    end
`else
    logic [1:0] unused_sigs;

    assign buf_hit     = 1'b0;
    assign buf_rd_dat  = '0;
    assign unused_sigs = {ic_inv_i, wb_fill};
`endif

    assign icpu_dat_o = dat_q;
    assign icpu_ack_o = ack_q;
    assign icpu_err_o = err_q;
    assign icpu_adr_o = cpu_adr_q;
    assign icpu_tag_o = tag_q;
    assign iwb_cyc_o  = cyc_q;
    assign iwb_stb_o  = cyc_q;
    assign iwb_adr_o  = wb_adr_q;
    assign iwb_sel_o  = 4'hf;
    assign iwb_we_o   = 1'b0;

endmodule

// File: tb/tb_or1200_if_bus_resp.sv
// Self-checking bench for or1200_if_bus_resp: vector table plus hand-written flush/retry/reset sequences.
// Refetch-buffer checks follow OR1200_IF_BUS_RESP_REFETCH_BUF_EN.
module tb_or1200_if_bus_resp;

    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_SILENT = 2;

`ifdef OR1200_IF_BUS_RESP_REFETCH_BUF_EN
    localparam bit HAS_BUF = 1'b1;
`else
    localparam bit HAS_BUF = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] adr;
        logic        inv;
        int          kind;
        int          delay;
        logic [31:0] wdat;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
        logic [3:0]  exp_tag;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic [31:0] adr;
        logic [3:0]  tag;
        logic        chk_dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        icpu_cycstb_i;
    logic [31:0] icpu_adr_i;
    logic        icpu_flush_i;
    logic [31:0] icpu_dat_o;
    logic        icpu_ack_o;
    logic        icpu_err_o;
    logic [31:0] icpu_adr_o;
    logic [3:0]  icpu_tag_o;
    logic        ic_inv_i;
    logic        iwb_cyc_o;
    logic        iwb_stb_o;
    logic [31:0] iwb_adr_o;
    logic [3:0]  iwb_sel_o;
    logic        iwb_we_o;
    logic [31:0] iwb_dat_i;
    logic        iwb_ack_i;
    logic        iwb_err_i;
    logic        iwb_rty_i;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[8];

    or1200_if_bus_resp #(
        .TIMEOUT(4),
        .TAG_NI (4'h0),
        .TAG_BE (4'hb)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .icpu_cycstb_i(icpu_cycstb_i),
        .icpu_adr_i   (icpu_adr_i),
        .icpu_flush_i (icpu_flush_i),
        .icpu_dat_o   (icpu_dat_o),
        .icpu_ack_o   (icpu_ack_o),
        .icpu_err_o   (icpu_err_o),
        .icpu_adr_o   (icpu_adr_o),
        .icpu_tag_o   (icpu_tag_o),
        .ic_inv_i     (ic_inv_i),
        .iwb_cyc_o    (iwb_cyc_o),
        .iwb_stb_o    (iwb_stb_o),
        .iwb_adr_o    (iwb_adr_o),
        .iwb_sel_o    (iwb_sel_o),
        .iwb_we_o     (iwb_we_o),
        .iwb_dat_i    (iwb_dat_i),
        .iwb_ack_i    (iwb_ack_i),
        .iwb_err_i    (iwb_err_i),
        .iwb_rty_i    (iwb_rty_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic take_resp(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected response ack=%b err=%b, want none", name, icpu_ack_o, icpu_err_o);
        end else begin
            e = sb.pop_front();
            check({name, " ack"}, 32'(icpu_ack_o), 32'(e.ack));
            check({name, " err"}, 32'(icpu_err_o), 32'(e.err));
            check({name, " adr"}, icpu_adr_o, e.adr);
            check({name, " tag"}, 32'(icpu_tag_o), 32'(e.tag));
            if (e.chk_dat) check({name, " dat"}, icpu_dat_o, e.dat);
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   cyc_cnt;
        bit   got;
        e.ack     = v.exp_ack;
        e.err     = v.exp_err;
        e.dat     = v.exp_dat;
        e.adr     = {v.adr[31:2], 2'b00};
        e.tag     = v.exp_tag;
        e.chk_dat = v.exp_ack;
        sb.push_back(e);
        icpu_cycstb_i = 1'b1;
        icpu_adr_i    = v.adr;
        ic_inv_i      = v.inv;
        cyc_cnt       = 0;
        got           = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            ic_inv_i  = 1'b0;
            iwb_ack_i = 1'b0;
            iwb_err_i = 1'b0;
            iwb_dat_i = '0;
            if (icpu_ack_o || icpu_err_o) begin
                got           = 1'b1;
                icpu_cycstb_i = 1'b0;
                take_resp(v.name);
            end else if (iwb_cyc_o) begin
                check({v.name, " wb_adr"}, iwb_adr_o, e.adr);
                if (v.kind != K_SILENT && cyc_cnt == v.delay) begin
                    if (v.kind == K_ACK) begin
                        iwb_ack_i = 1'b1;
                        iwb_dat_i = v.wdat;
                    end else begin
                        iwb_err_i = 1'b1;
                    end
                end
                cyc_cnt++;
            end
        end
        check({v.name, " responded"}, 32'(got), 32'd1);
        check({v.name, " cyc_cycles"}, 32'(cyc_cnt), 32'(v.exp_cyc));
        if (!got) begin
            icpu_cycstb_i = 1'b0;
            sb.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, " no ack"}, 32'(icpu_ack_o), 32'd0);
        check({name, " no err"}, 32'(icpu_err_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        vec_t v;

        vecs[0] = '{name:"ack_104",  adr:32'h0000_0104, inv:1'b0, kind:K_ACK,    delay:0, wdat:32'h1500_0000,
                    exp_ack:1'b1, exp_err:1'b0, exp_dat:32'h1500_0000, exp_tag:4'h0, exp_cyc:1};
        vecs[1] = '{name:"misal_102", adr:32'h0000_0102, inv:1'b0, kind:K_ACK,   delay:0, wdat:32'h0,
                    exp_ack:1'b0, exp_err:1'b1, exp_dat:32'h0, exp_tag:4'hb, exp_cyc:0};
        vecs[2] = '{name:"err_200",  adr:32'h0000_0200, inv:1'b0, kind:K_ERR,    delay:1, wdat:32'h0,
                    exp_ack:1'b0, exp_err:1'b1, exp_dat:32'h0, exp_tag:4'hb, exp_cyc:2};
        vecs[3] = '{name:"tmo_300",  adr:32'h0000_0300, inv:1'b0, kind:K_SILENT, delay:0, wdat:32'h0,
                    exp_ack:1'b0, exp_err:1'b1, exp_dat:32'h0, exp_tag:4'hb, exp_cyc:4};
        vecs[4] = '{name:"ack_40c",  adr:32'h0000_040c, inv:1'b0, kind:K_ACK,    delay:2, wdat:32'ha5a5_1234,
                    exp_ack:1'b1, exp_err:1'b0, exp_dat:32'ha5a5_1234, exp_tag:4'h0, exp_cyc:3};
        vecs[5] = '{name:"ack_top",  adr:32'hffff_fffc, inv:1'b0, kind:K_ACK,    delay:0, wdat:32'hdead_beef,
                    exp_ack:1'b1, exp_err:1'b0, exp_dat:32'hdead_beef, exp_tag:4'h0, exp_cyc:1};
        vecs[6] = '{name:"misal_203", adr:32'h0000_0203, inv:1'b0, kind:K_ACK,   delay:0, wdat:32'h0,
                    exp_ack:1'b0, exp_err:1'b1, exp_dat:32'h0, exp_tag:4'hb, exp_cyc:0};
        vecs[7] = '{name:"ack_208",  adr:32'h0000_0208, inv:1'b0, kind:K_ACK,    delay:1, wdat:32'h1234_5678,
                    exp_ack:1'b1, exp_err:1'b0, exp_dat:32'h1234_5678, exp_tag:4'h0, exp_cyc:2};

        rst           = 1'b1;
        icpu_cycstb_i = 1'b0;
        icpu_adr_i    = '0;
        icpu_flush_i  = 1'b0;
        ic_inv_i      = 1'b0;
        iwb_dat_i     = '0;
        iwb_ack_i     = 1'b0;
        iwb_err_i     = 1'b0;
        iwb_rty_i     = 1'b0;
        repeat (2) @(negedge clk);

        check("rst cyc",      32'(iwb_cyc_o),  32'd0);
        check("rst stb",      32'(iwb_stb_o),  32'd0);
        check("rst wb_adr",   iwb_adr_o,       32'd0);
        check("rst sel",      32'(iwb_sel_o),  32'hf);
        check("rst we",       32'(iwb_we_o),   32'd0);
        check("rst dat",      icpu_dat_o,      32'd0);
        check("rst cpu_adr",  icpu_adr_o,      32'd0);
        check("rst tag",      32'(icpu_tag_o), 32'h0);
        check_quiet("rst");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Flush one cycle into the bus cycle: cyc held until the slave acks, no response.
        icpu_cycstb_i = 1'b1;
        icpu_adr_i    = 32'h0000_0500;
        @(negedge clk);
        check("flush cyc0", 32'(iwb_cyc_o), 32'd1);
        icpu_flush_i  = 1'b1;
        icpu_cycstb_i = 1'b0;
        @(negedge clk);
        icpu_flush_i = 1'b0;
        check("flush drain cyc1", 32'(iwb_cyc_o), 32'd1);
        check("flush drain stb1", 32'(iwb_stb_o), 32'd1);
        check_quiet("flush c1");
        @(negedge clk);
        check("flush drain cyc2", 32'(iwb_cyc_o), 32'd1);
        check_quiet("flush c2");
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'hffff_0000;
        @(negedge clk);
        iwb_ack_i = 1'b0;
        iwb_dat_i = '0;
        check("flush end cyc", 32'(iwb_cyc_o), 32'd0);
        check_quiet("flush c3");
        @(negedge clk);
        check_quiet("flush c4");
        run_vec('{name:"after_flush", adr:32'h0000_0504, inv:1'b0, kind:K_ACK, delay:0, wdat:32'h5050_5050,
                  exp_ack:1'b1, exp_err:1'b0, exp_dat:32'h5050_5050, exp_tag:4'h0, exp_cyc:1});

        // Retry once: one-cycle gap, same address reissued, single ack.
        e = '{ack:1'b1, err:1'b0, dat:32'h0bad_cafe, adr:32'h0000_0600, tag:4'h0, chk_dat:1'b1};
        sb.push_back(e);
        icpu_cycstb_i = 1'b1;
        icpu_adr_i    = 32'h0000_0600;
        @(negedge clk);
        check("rty cyc0", 32'(iwb_cyc_o), 32'd1);
        iwb_rty_i = 1'b1;
        @(negedge clk);
        iwb_rty_i = 1'b0;
        check("rty gap cyc", 32'(iwb_cyc_o), 32'd0);
        check_quiet("rty gap");
        @(negedge clk);
        check("rty reissue cyc", 32'(iwb_cyc_o), 32'd1);
        check("rty reissue adr", iwb_adr_o, 32'h0000_0600);
        iwb_ack_i = 1'b1;
        iwb_dat_i = 32'h0bad_cafe;
        @(negedge clk);
        iwb_ack_i     = 1'b0;
        iwb_dat_i     = '0;
        icpu_cycstb_i = 1'b0;
        take_resp("rty resp");
        check("rty end cyc", 32'(iwb_cyc_o), 32'd0);
        @(negedge clk);
        check_quiet("rty pulse");

        // Flush in the same cycle as the slave ack: cyc drops, response suppressed.
        icpu_cycstb_i = 1'b1;
        icpu_adr_i    = 32'h0000_0700;
        @(negedge clk);
        check("flack cyc0", 32'(iwb_cyc_o), 32'd1);
        icpu_flush_i  = 1'b1;
        icpu_cycstb_i = 1'b0;
        iwb_ack_i     = 1'b1;
        iwb_dat_i     = 32'h7777_7777;
        @(negedge clk);
        icpu_flush_i = 1'b0;
        iwb_ack_i    = 1'b0;
        iwb_dat_i    = '0;
        check("flack cyc", 32'(iwb_cyc_o), 32'd0);
        check_quiet("flack c1");
        @(negedge clk);
        check_quiet("flack c2");

        // Refetch: with the buffer a repeat of the last acked word hits without a bus cycle.
        run_vec('{name:"rf_fill", adr:32'h0000_0200, inv:1'b0, kind:K_ACK, delay:0, wdat:32'h1111_0000,
                  exp_ack:1'b1, exp_err:1'b0, exp_dat:32'h1111_0000, exp_tag:4'h0, exp_cyc:1});
        v = '{name:"rf_again", adr:32'h0000_0200, inv:1'b0, kind:K_ACK, delay:0, wdat:32'h1111_0001,
              exp_ack:1'b1, exp_err:1'b0, exp_dat:32'h1111_0000, exp_tag:4'h0, exp_cyc:0};
        if (!HAS_BUF) begin
            v.exp_dat = 32'h1111_0001;
            v.exp_cyc = 1;
        end
        run_vec(v);
        run_vec('{name:"rf_inv_hit", adr:32'h0000_0200, inv:1'b1, kind:K_ACK, delay:0, wdat:32'h2222_0000,
                  exp_ack:1'b1, exp_err:1'b0, exp_dat:32'h2222_0000, exp_tag:4'h0, exp_cyc:1});
        ic_inv_i = 1'b1;
        @(negedge clk);
        ic_inv_i = 1'b0;
        run_vec('{name:"rf_after_inv", adr:32'h0000_0200, inv:1'b0, kind:K_ACK, delay:0, wdat:32'h3333_0000,
                  exp_ack:1'b1, exp_err:1'b0, exp_dat:32'h3333_0000, exp_tag:4'h0, exp_cyc:1});

        // Reset mid-transaction drops cyc at once and gives no response.
        icpu_cycstb_i = 1'b1;
        icpu_adr_i    = 32'h0000_0800;
        @(negedge clk);
        check("mid_rst cyc0", 32'(iwb_cyc_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        icpu_cycstb_i = 1'b0;
        check("mid_rst cyc",     32'(iwb_cyc_o),  32'd0);
        check("mid_rst wb_adr",  iwb_adr_o,       32'd0);
        check("mid_rst cpu_adr", icpu_adr_o,      32'd0);
        check("mid_rst dat",     icpu_dat_o,      32'd0);
        check("mid_rst tag",     32'(icpu_tag_o), 32'h0);
        check_quiet("mid_rst");
        @(negedge clk);
        check_quiet("mid_rst after");

        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
